mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares the single memory port between the instruction-fetch requester (read-only, word) and the data requester (loads/stores of byte, half or word size).
- Sits between the fetch stage, the MEM stage and the memory.
- Arbitrates between the two requesters, with a starvation guard for fetch.
- Generates word-aligned addresses and byte enables, replicates store data across lanes, and extracts and extends load data.
- Sequences one outstanding memory transaction at a time.

Parameters:
- ADDR_W, 32, address width.
- STARVE_LIMIT, 4, number of consecutive data grants made while fetch waits; once reached, fetch wins the next arbitration.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- if_req  in  1  fetch request valid; held with if_addr until if_done
- if_addr  in  ADDR_W  fetch byte address; bits [1:0] ignored
- if_done  out  1  one-cycle pulse: fetch complete, if_rdata valid
- if_rdata  out  32  fetched instruction word
- d_req  in  1  data request valid; held with all d_* inputs until d_done
- d_op  in  mem_op_e  MEM_LD or MEM_ST
- d_sz  in  mem_sz_e  SZ_B, SZ_H or SZ_W
- d_sgnd  in  1  sign-extend load (1) or zero-extend load (0)
- d_addr  in  ADDR_W  data byte address
- d_wdata  in  32  store data, right-justified
- d_done  out  1  one-cycle pulse: data access complete
- d_err  out  1  valid with d_done: misaligned access or MEM_NONE, no memory access made
- d_rdata  out  32  extended load data, valid with d_done when d_op = MEM_LD
- mem_req  out  1  memory request; held until mem_ack
- mem_we  out  1  write enable
- mem_addr  out  ADDR_W  word address, {addr[ADDR_W-1:2], 2'b00}
- mem_be  out  4  byte enables, little-endian; bit i covers bits [8i+7:8i]
- mem_wdata  out  32  lane-replicated store data
- mem_ack  in  1  memory completion; mem_rdata valid in the same cycle
- mem_rdata  in  32  memory read word

Behaviour:
- Interface is decided: one clock `clk`, synchronous active-high reset `rst`.
- All outputs are registered. Reset values:
  - state = IDLE, starve_cnt = 0;
  - mem_req, mem_we, if_done, d_done, d_err = 0;
  - mem_addr, mem_be, mem_wdata, if_rdata, d_rdata = 0.
- FSM states: IDLE, MEM_I, MEM_D, RESP_I, RESP_D.
- IDLE arbitration (sampled every IDLE cycle):
  - Only if_req high: go to MEM_I.
  - Only d_req high: if the data access is illegal, go to RESP_D with err set; otherwise go to MEM_D.
  - Both high: fetch wins if starve_cnt == STARVE_LIMIT; otherwise data wins.
- starve_cnt:
  - Increments, saturating at STARVE_LIMIT, on a data grant while if_req is high.
  - Clears on a fetch grant, and on any IDLE cycle with if_req low.
- Grant cycle: mem_req, mem_we, mem_addr, mem_be and mem_wdata are loaded. mem_req is high from the cycle after the grant.
- MEM_x: mem_req and all mem_* outputs stay stable until mem_ack. On mem_ack:
  - mem_req drops;
  - mem_rdata is captured and processed;
  - go to RESP_x.
- RESP_x: the corresponding done pulses for one cycle, then go to IDLE.
  - Minimum latency from req to done is 3 cycles with mem_ack asserted one cycle after mem_req rises.
- Requester rule: a requester drops req in the cycle after done unless it has a new request. A req seen in IDLE is always a new request.
- Illegal data access:
  - SZ_H with addr[0] = 1, SZ_W with addr[1:0] != 0, or d_op = MEM_NONE.
  - No mem_req is issued; d_done = 1 with d_err = 1, d_rdata = 0, one cycle after the grant.
  - Counts as a data grant for starve_cnt.
- Byte enables:
  - SZ_B: 4'b0001 << addr[1:0].
  - SZ_H: addr[1] ? 4'b1100 : 4'b0011.
  - SZ_W: 4'b1111.
- mem_we = (d_op == MEM_ST). Fetch accesses: mem_we = 0, mem_be = 4'b1111.
- Store data replication:
  - SZ_B: {4{wdata[7:0]}}.
  - SZ_H: {2{wdata[15:0]}}.
  - SZ_W: wdata.
- Load data extraction:
  - Select the lane from mem_rdata using addr[1:0].
  - Extend to 32 bits, sign or zero per d_sgnd.
  - SZ_W: pass the word through unchanged.
- Stores: d_rdata = 0 on done.
- mem_ack while in IDLE or RESP_x is ignored.
- rst asserted mid-transaction: next cycle is IDLE with all outputs at reset values. mem_req drops, no done is issued, and an in-flight mem_ack is ignored.

Test Plan:
- Fetch only: if_addr = 0x0000_0103, memory acks 2 cycles after mem_req with 0x2402_0005.
  - Expect mem_addr = 0x100, mem_be = 4'hF, mem_we = 0.
  - Expect if_done one cycle after ack with if_rdata = 0x2402_0005.
- Signed byte load: d_addr = 0x202, SZ_B, d_sgnd = 1, mem_rdata = 0x0080_0000.
  - Expect mem_be = 4'b0100 and d_rdata = 0xFFFF_FF80.
  - Repeat with d_sgnd = 0: expect d_rdata = 0x0000_0080.
- Half store: d_addr = 0x302, SZ_H, d_wdata = 0x1234_ABCD.
  - Expect mem_we = 1, mem_be = 4'b1100, mem_wdata = 0xABCD_ABCD, and d_done with d_err = 0.
- Misaligned word load: d_addr = 0x401, SZ_W.
  - Expect no mem_req; d_done = 1, d_err = 1, d_rdata = 0.
- Starvation: if_req and d_req held continuously, STARVE_LIMIT = 4.
  - Expect the grant sequence D, D, D, D, I, D, D, D, D, I.
- Reset in MEM_D (mem_req high, no ack yet), then mem_ack pulses the cycle after rst.
  - Expect mem_req = 0, no d_done, FSM in IDLE.
  - Expect a following fetch to complete normally.

Source files
------------

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Shares one memory port between instruction fetch and data access,
//            with a starvation guard for fetch and load/store lane handling.
// Revision : 1.0 - initial release
// ============================================================================

package mem_port_arbiter_pkg;
    typedef enum logic [1:0] {MEM_NONE = 2'd0, MEM_LD = 2'd1, MEM_ST = 2'd2} mem_op_e;
    typedef enum logic [1:0] {SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2} mem_sz_e;
endpackage

module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [31:0]       if_rdata,
    input  logic              d_req,
    input  mem_op_e           d_op,
    input  mem_sz_e           d_sz,
    input  logic              d_sgnd,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_done,
    output logic              d_err,
    output logic [31:0]       d_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata
);

    localparam int                c_cnt_w     = $clog2(STARVE_LIMIT + 1);
    localparam logic [c_cnt_w-1:0] c_limit     = c_cnt_w'(STARVE_LIMIT);
    localparam logic [ADDR_W-1:0] c_word_mask = {{(ADDR_W-2){1'b1}}, 2'b00};

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_MEM_I  = 3'd1,
        ST_MEM_D  = 3'd2,
        ST_RESP_I = 3'd3,
        ST_RESP_D = 3'd4
    } state_e;

    state_e               r_state;
    logic [c_cnt_w-1:0]   r_starve_cnt;
    logic [1:0]           r_ld_lane;
    mem_sz_e              r_ld_sz;
    logic                 r_ld_sgnd;
    logic                 r_ld_is_ld;

    logic                 w_grant_i;
    logic                 w_d_illegal;
    logic [3:0]           w_be;
    logic [31:0]          w_wdata;
    logic [7:0]           w_byte;
    logic [15:0]          w_half;
    logic [31:0]          w_ld_data;

    // Fetch wins only when it is alone or has waited through STARVE_LIMIT data grants.
    assign w_grant_i = if_req && (!d_req || (r_starve_cnt == c_limit));

    always_comb begin
        w_d_illegal = 1'b0;
        w_be        = 4'b1111;
        w_wdata     = d_wdata;
        case (d_sz)
            SZ_B: begin
                w_be    = 4'b0001 << d_addr[1:0];
                w_wdata = {4{d_wdata[7:0]}};
            end
            SZ_H: begin
                w_d_illegal = d_addr[0];
                w_be        = d_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata     = {2{d_wdata[15:0]}};
            end
            default: begin
                w_d_illegal = (d_addr[1:0] != 2'b00);
            end
        endcase
        if ((d_op != MEM_LD) && (d_op != MEM_ST)) begin
            w_d_illegal = 1'b1;
        end
    end

    always_comb begin
        w_byte = mem_rdata[7:0];
        case (r_ld_lane)
            2'd1:    w_byte = mem_rdata[15:8];
            2'd2:    w_byte = mem_rdata[23:16];
            2'd3:    w_byte = mem_rdata[31:24];
            default: w_byte = mem_rdata[7:0];
        endcase
        w_half = r_ld_lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (r_ld_sz)
            SZ_B:    w_ld_data = {{24{r_ld_sgnd & w_byte[7]}}, w_byte};
            SZ_H:    w_ld_data = {{16{r_ld_sgnd & w_half[15]}}, w_half};
            default: w_ld_data = mem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_starve_cnt <= '0;
            r_ld_lane    <= 2'b00;
            r_ld_sz      <= SZ_B;
            r_ld_sgnd    <= 1'b0;
            r_ld_is_ld   <= 1'b0;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_be       <= 4'b0000;
            mem_wdata    <= '0;
            if_done      <= 1'b0;
            if_rdata     <= '0;
            d_done       <= 1'b0;
            d_err        <= 1'b0;
            d_rdata      <= '0;
        end else begin
            if_done <= 1'b0;
            d_done  <= 1'b0;
            d_err   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_i) begin
                        r_state      <= ST_MEM_I;
                        r_starve_cnt <= '0;
                        mem_req      <= 1'b1;
                        mem_we       <= 1'b0;
                        mem_addr     <= if_addr & c_word_mask;
                        mem_be       <= 4'b1111;
                        mem_wdata    <= '0;
                    end else if (d_req) begin
                        // Cannot overflow: at the limit a waiting fetch takes the grant.
                        r_starve_cnt <= if_req ? r_starve_cnt + 1'b1 : '0;
                        if (w_d_illegal) begin
                            r_state <= ST_RESP_D;
                            d_done  <= 1'b1;
                            d_err   <= 1'b1;
                            d_rdata <= '0;
                        end else begin
                            r_state    <= ST_MEM_D;
                            mem_req    <= 1'b1;
                            mem_we     <= (d_op == MEM_ST);
                            mem_addr   <= d_addr & c_word_mask;
                            mem_be     <= w_be;
                            mem_wdata  <= w_wdata;
                            r_ld_lane  <= d_addr[1:0];
                            r_ld_sz    <= d_sz;
                            r_ld_sgnd  <= d_sgnd;
                            r_ld_is_ld <= (d_op == MEM_LD);
                        end
                    end else begin
                        r_starve_cnt <= '0;
                    end
                end
                ST_MEM_I: begin
                    if (mem_ack) begin
                        r_state  <= ST_RESP_I;
                        mem_req  <= 1'b0;
                        if_rdata <= mem_rdata;
                        if_done  <= 1'b1;
                    end
                end
                ST_MEM_D: begin
                    if (mem_ack) begin
                        r_state <= ST_RESP_D;
                        mem_req <= 1'b0;
                        d_rdata <= r_ld_is_ld ? w_ld_data : 32'h0;
                        d_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
